// File: rtl/pmem_arbiter_if.sv
// Single-line physical-memory handshake shared by each cache port and the memory port.
// master drives the command; slave returns the read line and completion.
interface pmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Arbitrates the I-cache and D-cache onto one physical-memory port, one line per grant.
// Optional macro PMEM_ARB_RR_EN: alternate winners on conflicts (otherwise D has fixed priority).
//
// state   | meaning
// IDLE    | no grant; also the mandatory gap cycle after every completion
// GRANT_I | I-cache owns the memory port
// GRANT_D | D-cache owns the memory port
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  pmem_arbiter_if.slave  i_port,
  pmem_arbiter_if.slave  d_port,
  pmem_arbiter_if.master mem_port
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t            state;
  logic              cmd_read;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [LINE_W-1:0] cmd_wdata;
  logic              last_d;

  logic i_req;
  logic d_req;
  logic pick_d;

  assign i_req = i_port.pmem_read | i_port.pmem_write;
  assign d_req = d_port.pmem_read | d_port.pmem_write;

`ifdef PMEM_ARB_RR_EN
  assign pick_d = d_req & (~i_req | ~last_d);
`else
  logic unused_last_d;
  assign pick_d        = d_req;
  assign unused_last_d = last_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_read    <= 1'b0;
      cmd_write   <= 1'b0;
      cmd_address <= '0;
      cmd_wdata   <= '0;
      last_d      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state       <= GRANT_D;
            cmd_write   <= d_port.pmem_write;
            cmd_read    <= d_port.pmem_read & ~d_port.pmem_write;
            cmd_address <= d_port.pmem_address;
            cmd_wdata   <= d_port.pmem_wdata;
          end else if (i_req) begin
            state       <= GRANT_I;
            cmd_write   <= i_port.pmem_write;
            cmd_read    <= i_port.pmem_read & ~i_port.pmem_write;
            cmd_address <= i_port.pmem_address;
            cmd_wdata   <= i_port.pmem_wdata;
          end
        end
        GRANT_I, GRANT_D: begin
          // address/wdata deliberately keep their last values after completion
          if (mem_port.pmem_resp) begin
            state     <= IDLE;
            cmd_read  <= 1'b0;
            cmd_write <= 1'b0;
            last_d    <= (state == GRANT_D);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_port.pmem_read    = cmd_read;
  assign mem_port.pmem_write   = cmd_write;
  assign mem_port.pmem_address = cmd_address;
  assign mem_port.pmem_wdata   = cmd_wdata;

  assign i_port.pmem_rdata = mem_port.pmem_rdata;
  assign d_port.pmem_rdata = mem_port.pmem_rdata;
  assign i_port.pmem_resp  = (state == GRANT_I) & mem_port.pmem_resp;
  assign d_port.pmem_resp  = (state == GRANT_D) & mem_port.pmem_resp;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios plus a randomized
// conflict run scored against an order/latency model of the arbitration rules.
module tb_pmem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) i_bus ();
  pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) d_bus ();
  pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) m_bus ();

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_port   (i_bus),
    .d_port   (d_bus),
    .mem_port (m_bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic drive_idle();
    i_bus.pmem_read = 1'b0; i_bus.pmem_write = 1'b0;
    i_bus.pmem_address = '0; i_bus.pmem_wdata = '0;
    d_bus.pmem_read = 1'b0; d_bus.pmem_write = 1'b0;
    d_bus.pmem_address = '0; d_bus.pmem_wdata = '0;
    m_bus.pmem_resp = 1'b0; m_bus.pmem_rdata = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int w = 0; w < LINE_W / 32; w++) l[w*32 +: 32] = $urandom();
    return l;
  endfunction

  task automatic test_reset();
    logic [ADDR_W+LINE_W+3:0] outs;
    rst_n = 1'b0;
    drive_idle();
    #3;
    outs = {m_bus.pmem_read, m_bus.pmem_write, m_bus.pmem_address, m_bus.pmem_wdata,
            i_bus.pmem_resp, d_bus.pmem_resp};
    n_cmp++;
    if (outs !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", outs); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    d_bus.pmem_read = 1'b1; d_bus.pmem_address = 32'h0000_0080;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (m_bus.pmem_read !== 1'b1) begin n_err++; $display("FAIL grant_d_before_reset: pmem_read=%b want 1", m_bus.pmem_read); end
    #2 rst_n = 1'b0;
    #1;
    outs = {m_bus.pmem_read, m_bus.pmem_write, m_bus.pmem_address, m_bus.pmem_wdata,
            i_bus.pmem_resp, d_bus.pmem_resp};
    n_cmp++;
    if (outs !== '0) begin n_err++; $display("FAIL reset_mid_grant: got %h want 0", outs); end
    d_bus.pmem_read = 1'b0; d_bus.pmem_address = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    outs = {m_bus.pmem_read, m_bus.pmem_write, m_bus.pmem_address, m_bus.pmem_wdata,
            i_bus.pmem_resp, d_bus.pmem_resp};
    n_cmp++;
    if (outs !== '0) begin n_err++; $display("FAIL post_release_outputs: got %h want 0", outs); end
    // stray response in IDLE must not produce a requester response or a grant
    @(posedge clk); #1 m_bus.pmem_resp = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({i_bus.pmem_resp, d_bus.pmem_resp} !== 2'b00) begin
      n_err++; $display("FAIL stray_resp: i=%b d=%b want 0 0", i_bus.pmem_resp, d_bus.pmem_resp);
    end
    @(posedge clk); #1;
    m_bus.pmem_resp = 1'b0;
    i_bus.pmem_read = 1'b1; i_bus.pmem_address = 32'h0000_0100;
    @(negedge clk);
    n_cmp++;
    if (m_bus.pmem_read !== 1'b0) begin n_err++; $display("FAIL stray_no_grant: pmem_read=%b want 0", m_bus.pmem_read); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (m_bus.pmem_read !== 1'b1 || m_bus.pmem_address !== 32'h0000_0100) begin
      n_err++; $display("FAIL after_stray_grant: read=%b addr=%h want 1 00000100", m_bus.pmem_read, m_bus.pmem_address);
    end
    @(posedge clk); #1 m_bus.pmem_resp = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    m_bus.pmem_resp = 1'b0; i_bus.pmem_read = 1'b0;
  endtask

  task automatic test_lone_i_read();
    logic [LINE_W-1:0] a5 = {(LINE_W/8){8'hA5}};
    int rd_cycles = 0, i_pulses = 0, d_pulses = 0;
    @(posedge clk); #1;
    i_bus.pmem_read = 1'b1; i_bus.pmem_address = 32'h0000_0040;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      m_bus.pmem_resp  = (c == 3);
      m_bus.pmem_rdata = (c == 3) ? a5 : '0;
      if (c == 4) i_bus.pmem_read = 1'b0;
      @(negedge clk);
      if (m_bus.pmem_read === 1'b1) rd_cycles++;
      if (i_bus.pmem_resp === 1'b1) i_pulses++;
      if (d_bus.pmem_resp !== 1'b0) d_pulses++;
      if (c == 3) begin
        n_cmp++;
        if (i_bus.pmem_rdata !== a5 || m_bus.pmem_address !== 32'h0000_0040) begin
          n_err++; $display("FAIL lone_i_data: rdata=%h addr=%h want a5.. 00000040", i_bus.pmem_rdata, m_bus.pmem_address);
        end
      end
    end
    n_cmp++;
    if (rd_cycles != 3) begin n_err++; $display("FAIL lone_i_read_cycles: got %0d want 3", rd_cycles); end
    n_cmp++;
    if (i_pulses != 1) begin n_err++; $display("FAIL lone_i_resp_pulses: got %0d want 1", i_pulses); end
    n_cmp++;
    if (d_pulses != 0) begin n_err++; $display("FAIL lone_i_d_resp: got %0d want 0", d_pulses); end
    m_bus.pmem_rdata = '0;
  endtask

  task automatic test_conflict();
    apply_reset();
    @(posedge clk); #1;
    i_bus.pmem_read = 1'b1; i_bus.pmem_address = 32'h0000_0200;
    d_bus.pmem_read = 1'b1; d_bus.pmem_address = 32'h0000_0300;
    @(negedge clk);
    @(posedge clk); #1 m_bus.pmem_resp = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (m_bus.pmem_read !== 1'b1 || m_bus.pmem_address !== 32'h0000_0300) begin
      n_err++; $display("FAIL conflict_first_d: read=%b addr=%h want 1 00000300", m_bus.pmem_read, m_bus.pmem_address);
    end
    n_cmp++;
    if ({d_bus.pmem_resp, i_bus.pmem_resp} !== 2'b10) begin
      n_err++; $display("FAIL conflict_d_resp: d=%b i=%b want 1 0", d_bus.pmem_resp, i_bus.pmem_resp);
    end
    @(posedge clk); #1;
    m_bus.pmem_resp = 1'b0; d_bus.pmem_read = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_bus.pmem_read !== 1'b0) begin n_err++; $display("FAIL conflict_idle_gap: read=%b want 0", m_bus.pmem_read); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (m_bus.pmem_read !== 1'b1 || m_bus.pmem_address !== 32'h0000_0200) begin
      n_err++; $display("FAIL conflict_i_second: read=%b addr=%h want 1 00000200", m_bus.pmem_read, m_bus.pmem_address);
    end
    @(posedge clk); #1 m_bus.pmem_resp = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({d_bus.pmem_resp, i_bus.pmem_resp} !== 2'b01) begin
      n_err++; $display("FAIL conflict_i_resp: d=%b i=%b want 0 1", d_bus.pmem_resp, i_bus.pmem_resp);
    end
    @(posedge clk); #1;
    m_bus.pmem_resp = 1'b0; i_bus.pmem_read = 1'b0;
  endtask

  task automatic test_command_latch();
    logic [LINE_W-1:0] w1 = {(LINE_W/16){16'h1234}};
    int hold = $urandom_range(2, 4);
    @(posedge clk); #1;
    d_bus.pmem_write = 1'b1; d_bus.pmem_read = 1'b1;
    d_bus.pmem_address = 32'h0000_1000; d_bus.pmem_wdata = w1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({m_bus.pmem_write, m_bus.pmem_read} !== 2'b10) begin
      n_err++; $display("FAIL latch_write_wins: write=%b read=%b want 1 0", m_bus.pmem_write, m_bus.pmem_read);
    end
    for (int c = 1; c <= hold; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        d_bus.pmem_address = 32'h0000_2000; d_bus.pmem_wdata = ~w1; d_bus.pmem_read = 1'b0;
      end
      m_bus.pmem_resp = (c == hold);
      @(negedge clk);
      n_cmp++;
      if (m_bus.pmem_address !== 32'h0000_1000 || m_bus.pmem_wdata !== w1 || m_bus.pmem_write !== 1'b1) begin
        n_err++; $display("FAIL latch_hold: addr=%h write=%b wdata=%h want 00001000 1 1234..",
                          m_bus.pmem_address, m_bus.pmem_write, m_bus.pmem_wdata);
      end
    end
    @(posedge clk); #1;
    m_bus.pmem_resp = 1'b0; d_bus.pmem_write = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_bus.pmem_write !== 1'b0 || m_bus.pmem_address !== 32'h0000_1000 || m_bus.pmem_wdata !== w1) begin
      n_err++; $display("FAIL latch_after_done: write=%b addr=%h want 0 00001000 (wdata held)",
                        m_bus.pmem_write, m_bus.pmem_address);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    d_bus.pmem_write = 1'b1; d_bus.pmem_address = 32'h0000_3000; d_bus.pmem_wdata = rand_line();
    @(negedge clk);
    @(posedge clk); #1 m_bus.pmem_resp = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (m_bus.pmem_write !== 1'b1 || d_bus.pmem_resp !== 1'b1) begin
      n_err++; $display("FAIL b2b_writeback: write=%b d_resp=%b want 1 1", m_bus.pmem_write, d_bus.pmem_resp);
    end
    @(posedge clk); #1;
    m_bus.pmem_resp = 1'b0;
    d_bus.pmem_write = 1'b0; d_bus.pmem_read = 1'b1; d_bus.pmem_address = 32'h0000_3400;
    @(negedge clk);
    n_cmp++;
    if ({m_bus.pmem_read, m_bus.pmem_write} !== 2'b00) begin
      n_err++; $display("FAIL b2b_idle: read=%b write=%b want 0 0", m_bus.pmem_read, m_bus.pmem_write);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({m_bus.pmem_read, m_bus.pmem_write} !== 2'b10 || m_bus.pmem_address !== 32'h0000_3400) begin
      n_err++; $display("FAIL b2b_fill: read=%b write=%b addr=%h want 1 0 00003400",
                        m_bus.pmem_read, m_bus.pmem_write, m_bus.pmem_address);
    end
    @(posedge clk); #1 m_bus.pmem_resp = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    m_bus.pmem_resp = 1'b0; d_bus.pmem_read = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_bus.pmem_read !== 1'b0) begin n_err++; $display("FAIL b2b_done: read=%b want 0", m_bus.pmem_read); end
  endtask

  // Model: both caches request continuously; the winner sequence is D first, then
  // alternating with round-robin, or always D with fixed priority.
  task automatic test_round_robin();
    logic [ADDR_W-1:0] i_addr, d_addr, exp_addr;
    logic [LINE_W-1:0] rd;
    logic exp_d;
    int lat;
    apply_reset();
    i_addr = $urandom() & 32'h7FFF_FFE0;
    d_addr = ($urandom() & 32'h7FFF_FFE0) | 32'h8000_0000;
    @(posedge clk); #1;
    i_bus.pmem_read = 1'b1; i_bus.pmem_address = i_addr;
    d_bus.pmem_read = 1'b1; d_bus.pmem_address = d_addr;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
`ifdef PMEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      exp_addr = exp_d ? d_addr : i_addr;
      lat = $urandom_range(1, 4);
      rd  = rand_line();
      for (int c = 1; c <= lat; c++) begin
        @(posedge clk); #1;
        m_bus.pmem_resp  = (c == lat);
        m_bus.pmem_rdata = rd;
        @(negedge clk);
        if (c == 1) begin
          n_cmp++;
          if (m_bus.pmem_read !== 1'b1 || m_bus.pmem_address !== exp_addr) begin
            n_err++; $display("FAIL rr_grant k=%0d: read=%b addr=%h want 1 %h", k, m_bus.pmem_read, m_bus.pmem_address, exp_addr);
          end
        end
        n_cmp++;
        if (d_bus.pmem_resp !== (c == lat && exp_d) || i_bus.pmem_resp !== (c == lat && !exp_d)) begin
          n_err++; $display("FAIL rr_resp_route k=%0d c=%0d: d=%b i=%b want %b %b", k, c,
                            d_bus.pmem_resp, i_bus.pmem_resp, (c == lat && exp_d), (c == lat && !exp_d));
        end
        if (c == lat) begin
          n_cmp++;
          if (i_bus.pmem_rdata !== rd || d_bus.pmem_rdata !== rd) begin
            n_err++; $display("FAIL rr_rdata k=%0d: i=%h d=%h want %h", k, i_bus.pmem_rdata, d_bus.pmem_rdata, rd);
          end
        end
      end
      @(posedge clk); #1;
      m_bus.pmem_resp = 1'b0;
      if (exp_d) begin
        d_addr = ($urandom() & 32'h7FFF_FFE0) | 32'h8000_0000; d_bus.pmem_address = d_addr;
      end else begin
        i_addr = $urandom() & 32'h7FFF_FFE0; i_bus.pmem_address = i_addr;
      end
      @(negedge clk);
      n_cmp++;
      if (m_bus.pmem_read !== 1'b0) begin n_err++; $display("FAIL rr_idle_gap k=%0d: read=%b want 0", k, m_bus.pmem_read); end
    end
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lone_i_read();
    test_conflict();
    test_command_latch();
    test_back_to_back();
    test_round_robin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
